// File: rtl/agc_gain_ctl.sv
// agc_gain_ctl: peak-driven AGC, fast attack / slow decay of an 8-bit gain word.
// Optional hang interval before decay is built only when AGC_HANG_EN is defined.
module agc_gain_ctl #(
  parameter logic [7:0] GINIT = 8'd128,
  parameter logic [6:0] HI    = 7'd96,
  parameter logic [6:0] LO    = 7'd48,
  parameter logic [7:0] ATK   = 8'd8,
  parameter logic [3:0] HANG  = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic [6:0] max,
  output logic       clr,
  output logic [7:0] gain,
  output logic       hold,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, LATCH, EVAL} state_t;
  state_t state;
  logic [6:0] pk;
  logic [8:0] dec, inc;
  logic [7:0] gdec, ginc;
  assign dec  = {1'b0, gain} - {1'b0, ATK};
  assign inc  = {1'b0, gain} + 9'd1;
  assign gdec = dec[8] ? 8'd0 : dec[7:0];
  assign ginc = inc[8] ? 8'hff : inc[7:0];
`ifdef AGC_HANG_EN
  logic [3:0] hang;
  assign hold = hang != 4'd0;
`else
  assign hold = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gain  <= GINIT;
      pk    <= 7'd0;
      clr   <= 1'b0;
      busy  <= 1'b0;
`ifdef AGC_HANG_EN
      hang  <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: if (stb) begin
          pk    <= max;
          state <= LATCH;
          clr   <= 1'b1;
          busy  <= 1'b1;
        end
        LATCH: begin
          clr   <= 1'b0;
          state <= EVAL;
        end
        EVAL: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (pk > HI) begin
            gain <= gdec;
`ifdef AGC_HANG_EN
            hang <= HANG;
`endif
          end else if (pk < LO) begin
`ifdef AGC_HANG_EN
            if (hang != 4'd0) hang <= hang - 4'd1;
            else gain <= ginc;
`else
            gain <= ginc;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_agc_gain_ctl.sv
// tb_agc_gain_ctl: directed plan plus random traffic against an evaluation-level reference model.
module tb_agc_gain_ctl;
  logic clk = 1'b0, rst = 1'b0, stb = 1'b0;
  logic [6:0] max = 7'd0;
  logic clr, hold, busy;
  logic [7:0] gain;
  int checks = 0, errors = 0;
  int mg = 128, mh = 0, mpk = 0, mph = 0;

  agc_gain_ctl dut (.clk(clk), .rst(rst), .stb(stb), .max(max), .clr(clr), .gain(gain), .hold(hold), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic s, input int m);
    if (!r) begin
      mph = 0; mg = 128; mh = 0; mpk = 0;
    end else if (mph == 0) begin
      if (s) begin mpk = m; mph = 1; end
    end else if (mph == 1) begin
      mph = 2;
    end else begin
      mph = 0;
      if (mpk > 96) begin
        mg = (mg - 8 < 0) ? 0 : mg - 8;
        mh = 15;
      end else if (mpk < 48) begin
`ifdef AGC_HANG_EN
        if (mh > 0) mh--;
        else mg = (mg + 1 > 255) ? 255 : mg + 1;
`else
        mg = (mg + 1 > 255) ? 255 : mg + 1;
`endif
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [6:0] m);
    @(negedge clk);
    rst = r; stb = s; max = m;
    @(posedge clk);
    model(r, s, int'(m));
    #1;
    chk("gain", int'(gain), mg);
    chk("clr", int'(clr), int'(mph == 1));
    chk("busy", int'(busy), int'(mph != 0));
`ifdef AGC_HANG_EN
    chk("hold", int'(hold), int'(mh != 0));
`else
    chk("hold", int'(hold), 0);
`endif
  endtask

  task automatic meas(input logic [6:0] m);
    cyc(1'b1, 1'b1, m);
    cyc(1'b1, 1'b0, 7'd0);
    cyc(1'b1, 1'b0, 7'd0);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 7'd0);
    cyc(1'b1, 1'b0, 7'd0);
    chk("reset_gain", int'(gain), 128);
    meas(7'd120);
    chk("attack_gain", int'(gain), 120);
    for (int i = 0; i < 17; i++) meas(7'd10);
`ifdef AGC_HANG_EN
    chk("decay_after_hang", int'(gain), 122);
`else
    chk("decay_no_hang", int'(gain), 137);
`endif
    meas(7'd64);
    cyc(1'b1, 1'b1, 7'd64);
    cyc(1'b1, 1'b1, 7'd127);
    cyc(1'b1, 1'b1, 7'd127);
    cyc(1'b1, 1'b0, 7'd0);
    for (int i = 0; i < 40 && mg >= 8; i++) meas(7'd127);
    for (int i = 0; i < 60 && mg != 4; i++) meas(mg > 4 ? 7'd127 : 7'd10);
    chk("gain_at_4", int'(gain), 4);
    meas(7'd127);
    chk("sat_zero", int'(gain), 0);
    meas(7'd127);
    chk("sat_zero_again", int'(gain), 0);
    for (int i = 0; i < 400 && mg != 255; i++) meas(7'd10);
    meas(7'd0);
    chk("sat_255", int'(gain), 255);
    cyc(1'b1, 1'b1, 7'd120);
    cyc(1'b1, 1'b0, 7'd0);
    cyc(1'b0, 1'b0, 7'd0);
    chk("midop_reset", int'(gain), 128);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 4), 7'($urandom_range(0, 127)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
